// File: rtl/zmod_link_tester_if.sv
// zmod_link_tester_if
//   Bundles the data and control signals of the ZMOD PRBS link tester.
//   The slave modport is the tester itself. The master modport is the
//   surrounding logic: the register block and the serdes/IO wrapper.
//
//   enable      run generator and checkers (low = idle)
//   clear_cnt   synchronous clear of all error counters
//   inject_err  per-lane one-cycle error injection mask
//   tx_data     registered PRBS bit per lane
//   rx_data     received bit per lane
//   locked      per-lane lock flag
//   all_locked  AND of locked, registered with it
//   err_cnt     packed saturating counters, lane i at [i*CNT_W +: CNT_W]
interface zmod_link_tester_if #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                   enable;
    logic                   clear_cnt;
    logic [LANES-1:0]       inject_err;
    logic [LANES-1:0]       tx_data;
    logic [LANES-1:0]       rx_data;
    logic [LANES-1:0]       locked;
    logic                   all_locked;
    logic [LANES*CNT_W-1:0] err_cnt;

    modport master (
        output enable, clear_cnt, inject_err, rx_data,
        input  tx_data, locked, all_locked, err_cnt
    );

    modport slave (
        input  enable, clear_cnt, inject_err, rx_data,
        output tx_data, locked, all_locked, err_cnt
    );
endinterface

// File: rtl/zmod_link_tester.sv
// zmod_link_tester
//   Multi-lane PRBS link tester for the ZMOD LVDS loopback path.
//   Each lane has its own PRBS generator and its own self-synchronising
//   checker. The generator produces one bit per clock, using
//   x^7+x^6+1 or x^15+x^14+1. The checker takes the received stream
//   through SYNC -> HUNT -> LOCKED. It reports the lane lock flag and a
//   saturating count of the mismatches seen while locked.
//
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   link   zmod_link_tester_if.slave: enable, clear_cnt, inject_err,
//          rx_data in; tx_data, locked, all_locked, err_cnt out
module zmod_link_tester #(
    parameter int LANES       = 4,
    parameter int PRBS_ORDER  = 7,
    parameter int LOCK_COUNT  = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    zmod_link_tester_if.slave link
);
    localparam int N  = PRBS_ORDER;
    localparam int SW = $clog2(N);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    if (!(PRBS_ORDER == 7 || PRBS_ORDER == 15)) begin : g_bad_order
        $error("zmod_link_tester: PRBS_ORDER must be 7 or 15");
    end
    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("zmod_link_tester: LANES must be 1..16");
    end
    if (LOCK_COUNT < 1 || UNLOCK_ERRS < 3) begin : g_bad_thresholds
        $error("zmod_link_tester: LOCK_COUNT >= 1 and UNLOCK_ERRS >= 3 required");
    end

    logic [N-1:0]     lfsr [LANES];
    logic [LANES-1:0] tx_q;
    logic             tx_v;
    logic [LANES-1:0] rx_q;
    logic             rx_v;
    logic [LANES-1:0] lock_nxt;
    logic             all_q;

    // Generator. Injection flips only the transmitted bit. The LFSR keeps
    // running clean, so a single injection is a single line error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lfsr[i] <= N'(i + 1);
            end
            tx_q <= '0;
            tx_v <= 1'b0;
        end else if (!link.enable) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lfsr[i] <= N'(i + 1);
            end
            tx_q <= '0;
            tx_v <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lfsr[i]  <= {lfsr[i][N-2:0], lfsr[i][N-1] ^ lfsr[i][N-2]};
                tx_q[i]  <= (lfsr[i][N-1] ^ lfsr[i][N-2]) ^ link.inject_err[i];
            end
            tx_v <= 1'b1;
        end
    end

    // RX capture stage. rx_v is also gated with enable. Without this, a
    // one-cycle enable drop would leave a stale valid flag behind. The
    // checker would then consume one bit early after the restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= '0;
            rx_v <= 1'b0;
        end else begin
            rx_q <= link.rx_data;
            rx_v <= tx_v & link.enable;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        chk_state_t       state;
        logic [N-1:0]     hist;
        logic [SW-1:0]    sync_cnt;
        logic [RW-1:0]    run;
        logic [MW-1:0]    miss;
        logic [CNT_W-1:0] cnt;
        logic             lock_r;
        logic             consume;
        logic             match;
        logic             lock_up;
        logic             lock_down;

        assign consume   = link.enable & rx_v;
        assign match     = (rx_q[g] == (hist[N-1] ^ hist[N-2]));
        assign lock_up   = (state == HUNT) && match && (run == RW'(LOCK_COUNT - 1));
        assign lock_down = (state == LOCKED) && !match && (miss == MW'(UNLOCK_ERRS - 1));

        // The next lock value is shared by lock_r and the all_locked
        // register, so both change on the same edge.
        assign lock_nxt[g] = !link.enable          ? 1'b0 :
                             (consume && lock_up)   ? 1'b1 :
                             (consume && lock_down) ? 1'b0 : lock_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= SYNC;
                hist     <= '0;
                sync_cnt <= '0;
                run      <= '0;
                miss     <= '0;
                lock_r   <= 1'b0;
            end else begin
                lock_r <= lock_nxt[g];
                if (!link.enable) begin
                    state    <= SYNC;
                    sync_cnt <= '0;
                    run      <= '0;
                    miss     <= '0;
                end else if (consume) begin
                    hist <= {hist[N-2:0], rx_q[g]};
                    unique case (state)
                        SYNC: begin
                            if (sync_cnt == SW'(N - 1)) begin
                                state    <= HUNT;
                                sync_cnt <= '0;
                                run      <= '0;
                            end else begin
                                sync_cnt <= sync_cnt + SW'(1);
                            end
                        end
                        HUNT: begin
                            if (!match) begin
                                run <= '0;
                            end else if (lock_up) begin
                                state <= LOCKED;
                                run   <= '0;
                                miss  <= '0;
                            end else begin
                                run <= run + RW'(1);
                            end
                        end
                        LOCKED: begin
                            if (match) begin
                                miss <= '0;
                            end else if (lock_down) begin
                                state <= HUNT;
                                miss  <= '0;
                                run   <= '0;
                            end else begin
                                miss <= miss + MW'(1);
                            end
                        end
                        default: state <= SYNC;
                    endcase
                end
            end
        end

        // Counts only mismatches seen while locked. It saturates at all-ones,
        // and clear_cnt takes priority over a mismatch in the same cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (link.clear_cnt) begin
                cnt <= '0;
            end else if (consume && (state == LOCKED) && !match && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign link.locked[g]                  = lock_r;
        assign link.err_cnt[g*CNT_W +: CNT_W]  = cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_q <= 1'b0;
        end else begin
            all_q <= &lock_nxt;
        end
    end

    assign link.tx_data    = tx_q;
    assign link.all_locked = all_q;
endmodule

// File: tb/tb_zmod_link_tester.sv
// tb_zmod_link_tester
//   Directed bench for zmod_link_tester with three instances:
//   - u0: the default configuration.
//   - u1: CNT_W=4, to exercise counter saturation.
//   - u2: PRBS_ORDER=15 with LANES=8.
//   All three run in loopback. The flip masks corrupt the RX lanes.
module tb_zmod_link_tester;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    zmod_link_tester_if #(.LANES(4), .CNT_W(16)) lk0 ();
    zmod_link_tester_if #(.LANES(4), .CNT_W(4))  lk1 ();
    zmod_link_tester_if #(.LANES(8), .CNT_W(16)) lk2 ();

    logic [3:0] flip0;
    logic [3:0] flip1;

    assign lk0.rx_data = lk0.tx_data ^ flip0;
    assign lk1.rx_data = lk1.tx_data ^ flip1;
    assign lk2.rx_data = lk2.tx_data;

    zmod_link_tester #(.LANES(4), .PRBS_ORDER(7), .LOCK_COUNT(16), .UNLOCK_ERRS(4), .CNT_W(16))
        u0 (.clk(clk), .rst_n(rst_n), .link(lk0.slave));
    zmod_link_tester #(.LANES(4), .PRBS_ORDER(7), .LOCK_COUNT(16), .UNLOCK_ERRS(4), .CNT_W(4))
        u1 (.clk(clk), .rst_n(rst_n), .link(lk1.slave));
    zmod_link_tester #(.LANES(8), .PRBS_ORDER(15), .LOCK_COUNT(16), .UNLOCK_ERRS(4), .CNT_W(16))
        u2 (.clk(clk), .rst_n(rst_n), .link(lk2.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_en(input logic v);
        lk0.enable = v;
        lk1.enable = v;
        lk2.enable = v;
    endtask

    int           e0, e1, e2, fe, re, bad, ones, sat_exp;
    logic [6:0]   t0, t1;
    logic [15:0]  cnt_at;
    logic [253:0] hist;
    logic         any_err, drop;

    initial begin
        rst_n = 1'b0;
        set_en(1'b0);
        lk0.clear_cnt = 1'b0; lk1.clear_cnt = 1'b0; lk2.clear_cnt = 1'b0;
        lk0.inject_err = '0;  lk1.inject_err = '0;  lk2.inject_err = '0;
        flip0 = '0;
        flip1 = '0;
        t0 = '0;
        t1 = '0;

        // Reset state
        @(posedge clk); #1;
        check("rst_tx_data",    128'(lk0.tx_data),    128'd0);
        check("rst_locked",     128'(lk0.locked),     128'd0);
        check("rst_all_locked", 128'(lk0.all_locked), 128'd0);
        check("rst_err_cnt",    128'(lk0.err_cnt),    128'd0);

        // Enable; the next rising edge is edge 1
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) set_en(1'b1);
        e0 = 0; e1 = 0; e2 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k <= 7) begin
                t0[k-1] = lk0.tx_data[0];
                t1[k-1] = lk0.tx_data[1];
            end
            if (k == 24) check("locked_before_edge25", 128'(lk0.locked), 128'd0);
            if (k == 25) check("locked_at_edge25",     128'(lk0.locked), 128'hF);
            if (lk0.all_locked && e0 == 0) e0 = k;
            if (lk1.all_locked && e1 == 0) e1 = k;
            if (lk2.all_locked && e2 == 0) e2 = k;
        end
        check("tx_lane0_first7",  128'(t0), 128'h60);
        check("tx_lane1_first7",  128'(t1), 128'h30);
        check("all_locked_edge",  128'(e0), 128'd25);
        check("cnt4_lock_edge",   128'(e1), 128'd25);
        check("prbs15_lock_edge", 128'(e2), 128'd33);

        // Soak in clean loopback
        any_err = 1'b0; drop = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (k < 254) hist[k] = lk0.tx_data[0];
            if (lk0.err_cnt != '0 || lk1.err_cnt != '0 || lk2.err_cnt != '0) any_err = 1'b1;
            if (!lk0.all_locked || !lk1.all_locked || !lk2.all_locked) drop = 1'b1;
        end
        bad = 0; ones = 0;
        for (int k = 0; k < 127; k++) begin
            if (hist[k] != hist[k+127]) bad++;
            if (hist[k]) ones++;
        end
        check("tx_lane0_period127", 128'(bad),     128'd0);
        check("tx_lane0_ones127",   128'(ones),    128'd64);
        check("soak_err_cnt_zero",  128'(any_err), 128'd0);
        check("soak_lock_held",     128'(drop),    128'd0);

        // Single injection: lane 2 of u0 and lane 7 of u2
        @(posedge clk); #1;
        lk0.inject_err = 4'b0100;
        lk2.inject_err = 8'h80;
        @(posedge clk); #1;
        lk0.inject_err = '0;
        lk2.inject_err = '0;
        drop = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (!lk0.all_locked || !lk2.all_locked) drop = 1'b1;
        end
        check("inject_lane2_err_cnt",   128'(lk0.err_cnt), 128'h0000_0003_0000_0000);
        check("inject_prbs15_lane7",    128'(lk2.err_cnt), 128'h0003_0000_0000_0000_0000_0000_0000_0000);
        check("inject_lock_held",       128'(drop),        128'd0);

        // Lane 1 inverted for 10 cycles
        @(posedge clk); #1;
        flip0 = 4'b0010;
        fe = 0; cnt_at = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (!lk0.locked[1] && fe == 0) begin
                fe = k;
                cnt_at = lk0.err_cnt[31:16];
            end
        end
        flip0 = '0;
        check("invert_drop_edge",  128'(fe),     128'd5);
        check("invert_cnt_at_drop", 128'(cnt_at), 128'd4);
        re = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (lk0.locked[1] && re == 0) re = k;
        end
        check("invert_relock_window", 128'(re >= 1 && re <= 25), 128'd1);
        check("invert_err_cnt_after", 128'(lk0.err_cnt), 128'h0000_0003_0004_0000);

        // Saturation on u1 lane 0 through repeated lock/unlock bursts
        for (int b = 1; b <= 5; b++) begin
            @(posedge clk); #1;
            flip1 = 4'b0001;
            repeat (10) @(posedge clk);
            #1 flip1 = '0;
            repeat (40) @(posedge clk);
            #1;
            sat_exp = (4 * b > 15) ? 15 : 4 * b;
            check("cnt4_saturate", 128'(lk1.err_cnt[3:0]), 128'(sat_exp));
            check("cnt4_relock",   128'(lk1.locked[0]),    128'd1);
        end

        // clear_cnt held across the mismatching edges that drop lock
        @(posedge clk); #1;
        flip1 = 4'b0001;
        @(posedge clk); #1;
        lk1.clear_cnt = 1'b1;
        repeat (4) @(posedge clk);
        #1 lk1.clear_cnt = 1'b0;
        check("clear_vs_mismatch_cnt",  128'(lk1.err_cnt),   128'd0);
        check("clear_vs_mismatch_lock", 128'(lk1.locked[0]), 128'd0);
        repeat (6) @(posedge clk);
        #1 flip1 = '0;

        // enable low for one edge: outputs idle, counters hold
        @(negedge clk) set_en(1'b0);
        @(posedge clk); #1;
        check("disable_tx_data",    128'(lk0.tx_data),    128'd0);
        check("disable_locked",     128'(lk0.locked),     128'd0);
        check("disable_all_locked", 128'(lk0.all_locked), 128'd0);
        check("disable_err_hold",   128'(lk0.err_cnt),    128'h0000_0003_0004_0000);
        @(negedge clk) set_en(1'b1);
        repeat (50) @(posedge clk);

        // Asynchronous reset mid-run, released with enable held high
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst_tx_data",    128'(lk0.tx_data),    128'd0);
        check("midrst_locked",     128'(lk0.locked),     128'd0);
        check("midrst_all_locked", 128'(lk0.all_locked), 128'd0);
        check("midrst_err_cnt",    128'(lk0.err_cnt),    128'd0);
        check("midrst_err_cnt_p15", 128'(lk2.err_cnt),   128'd0);
        @(negedge clk) rst_n = 1'b1;
        e0 = 0; e2 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (lk0.all_locked && e0 == 0) e0 = k;
            if (lk2.all_locked && e2 == 0) e2 = k;
        end
        check("midrst_relock_edge",        128'(e0), 128'd25);
        check("midrst_prbs15_relock_edge", 128'(e2), 128'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
